// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the test/control logic (master)
// and the ALU operation sequencer (slave).
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_bit;
  logic [3:0] rsp_digit;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_bit, rsp_digit
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_bit, rsp_digit
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: launches operands/select to a combinational ALU,
// waits SETTLE_CYCLES, samples the result and returns it over valid/ready.
// Optional exhaustive A/B sweep is built only when ALUSEQ_SWEEP_EN is defined.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [2:0]          alu_sel,
  input  logic                alu_out,
  input  logic [3:0]          alu_digit,
  input  logic                sweep_start,
  output logic                sweep_done,
  output logic [8:0]          sweep_count
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

`ifdef ALUSEQ_SWEEP_EN
  typedef enum logic [1:0] {IDLE, SETTLE, RESP, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             rsp_valid_q;
  logic             rsp_bit_q;
  logic [3:0]       rsp_digit_q;
  logic             accept;
  logic             capture;
  logic             sweep_go;
  logic             sweep_step;
  logic             sweep_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    sweep_go   = 1'b0;
    sweep_step = 1'b0;
    sweep_last = 1'b0;
    case (state)
      IDLE: begin
`ifdef ALUSEQ_SWEEP_EN
        if (sweep_start) begin
          sweep_go   = 1'b1;
          state_next = SWEEP;
        end else if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
`else
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
`endif
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
`ifdef ALUSEQ_SWEEP_EN
      SWEEP: begin
        if (cnt == '0) begin
          sweep_step = 1'b1;
          if ({alu_b, alu_a} == 8'hFF) begin
            sweep_last = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Settle counter: reloaded on every launch, counts down while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept || sweep_go || sweep_step) begin
      cnt <= CNT_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // ALU drive registers: only change on accept or sweep step, so the ALU never sees a glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      alu_a   <= bus.req_a;
      alu_b   <= bus.req_b;
      alu_sel <= bus.req_op;
    end else if (sweep_go) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= bus.req_op;
    end else if (sweep_step) begin
      {alu_b, alu_a} <= {alu_b, alu_a} + 8'd1;
    end
  end

  // Response capture and valid flag; data persists after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      rsp_digit_q <= '0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_bit_q   <= alu_out;
      rsp_digit_q <= alu_digit;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_bit   = rsp_bit_q;
  assign bus.rsp_digit = rsp_digit_q;

`ifdef ALUSEQ_SWEEP_EN
  logic       sweep_done_q;
  logic [8:0] sweep_count_q;

  // Sweep accumulator and end-of-sweep pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_count_q <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      sweep_done_q <= sweep_last;
      if (sweep_go)        sweep_count_q <= '0;
      else if (sweep_step) sweep_count_q <= sweep_count_q + 9'(alu_out);
    end
  end

  assign sweep_done  = sweep_done_q;
  assign sweep_count = sweep_count_q;
`else
  logic sweep_start_unused;
  assign sweep_start_unused = sweep_start;
  assign sweep_done         = 1'b0;
  assign sweep_count        = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU model.
module tb_alu_op_sequencer;
  localparam int unsigned S = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_digit;
  logic [2:0] alu_sel;
  logic       alu_out;
  logic       sweep_start;
  logic       sweep_done;
  logic [8:0] sweep_count;

  int         checks   = 0;
  int         failures = 0;
  int         mode     = 0;
  logic [7:0] salt     = '0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_digit(alu_digit),
    .sweep_start(sweep_start), .sweep_done(sweep_done), .sweep_count(sweep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: mode 0 = constant from salt, 1 = hash of inputs, 2 = out=A[0]
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel, input int md,
                                           input logic [7:0] s);
    case (md)
      0:       return {s[4], s[3:0]};
      1:       return {^{a, b, sel, s}, a + b + {1'b0, sel} + s[3:0]};
      default: return {a[0], b};
    endcase
  endfunction

  always_comb {alu_out, alu_digit} = alu_model(alu_a, alu_b, alu_sel, mode, salt);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request: accept, settle latency, optional backpressure with changing ALU, handshake
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input int unsigned hold);
    logic [4:0] exp;
    bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.req_valid = 1'b1;
    check("op_ready_before", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("op_alu_at_accept", {alu_b, alu_a, alu_sel}, {b, a, op});
    check("op_busy", bus.req_ready, 0);
    exp = alu_model(a, b, op, mode, salt);
    for (int unsigned i = 1; i <= S; i++) begin
      tick();
      check("op_alu_stable", {alu_b, alu_a, alu_sel}, {b, a, op});
      check("op_valid_latency", bus.rsp_valid, (i == S) ? 1 : 0);
    end
    check("op_rsp_bit", bus.rsp_bit, exp[4]);
    check("op_rsp_digit", bus.rsp_digit, exp[3:0]);
    for (int unsigned h = 0; h < hold; h++) begin
      salt = salt + 8'h37;
      tick();
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_rsp", {bus.rsp_bit, bus.rsp_digit}, exp);
      check("bp_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("hs_valid_clear", bus.rsp_valid, 0);
    check("hs_ready", bus.req_ready, 1);
    check("hs_rsp_held", {bus.rsp_bit, bus.rsp_digit}, exp);
  endtask

  initial begin
    logic [4:0]  e1, e2;
    logic [3:0]  a2, b2;
    logic [2:0]  op2;
    int unsigned done_at, rv_seen, exp_cnt;
    logic [7:0]  v;

    rst_n = 1'b0;
    sweep_start = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu", {alu_b, alu_a, alu_sel}, 0);
    check("rst_rsp_data", {bus.rsp_bit, bus.rsp_digit}, 0);
    check("rst_sweep", {sweep_done, sweep_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single op, ALU returns out=1 digit=9
    mode = 0; salt = 8'h19;
    do_op(4'h5, 4'hA, 3'b101, 0);

    // Backpressure for 10 cycles while ALU output changes
    mode = 1; salt = 8'h2C;
    do_op(4'h3, 4'hE, 3'b010, 10);

    // Back-to-back: req_valid held high across two requests
    mode = 1; salt = 8'hA5;
    a2 = 4'hC; b2 = 4'h1; op2 = 3'b110;
    e1 = alu_model(4'h7, 4'h9, 3'b011, mode, salt);
    e2 = alu_model(a2, b2, op2, mode, salt);
    bus.req_a = 4'h7; bus.req_b = 4'h9; bus.req_op = 3'b011;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    bus.req_a = a2; bus.req_b = b2; bus.req_op = op2;
    for (int unsigned i = 1; i <= S; i++) begin
      tick();
      check("b2b_alu1_stable", {alu_b, alu_a, alu_sel}, {4'h9, 4'h7, 3'b011});
      check("b2b_busy1", bus.req_ready, 0);
    end
    check("b2b_valid1", bus.rsp_valid, 1);
    check("b2b_rsp1", {bus.rsp_bit, bus.rsp_digit}, e1);
    tick();
    check("b2b_hs1_valid", bus.rsp_valid, 0);
    check("b2b_bubble_ready", bus.req_ready, 1);
    check("b2b_bubble_alu", {alu_b, alu_a, alu_sel}, {4'h9, 4'h7, 3'b011});
    tick();
    bus.req_valid = 1'b0;
    check("b2b_accept2", {alu_b, alu_a, alu_sel}, {b2, a2, op2});
    check("b2b_busy2", bus.req_ready, 0);
    for (int unsigned i = 1; i <= S; i++) begin
      tick();
      check("b2b_alu2_stable", {alu_b, alu_a, alu_sel}, {b2, a2, op2});
      check("b2b_valid2_latency", bus.rsp_valid, (i == S) ? 1 : 0);
    end
    check("b2b_rsp2", {bus.rsp_bit, bus.rsp_digit}, e2);
    tick();
    bus.rsp_ready = 1'b0;
    check("b2b_hs2", {bus.rsp_valid, bus.req_ready}, 2'b01);

    // Reset in the middle of SETTLE drops the operation
    bus.req_a = 4'hF; bus.req_b = 4'h6; bus.req_op = 3'b111; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_alu", {alu_b, alu_a, alu_sel}, 0);
    check("mid_rst_rsp", {bus.rsp_valid, bus.rsp_bit, bus.rsp_digit}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_seen = 0;
    for (int unsigned i = 0; i < S + 3; i++) begin
      tick();
      if (bus.rsp_valid) rv_seen++;
    end
    check("mid_rst_no_rsp", rv_seen, 0);
    mode = 1; salt = 8'h5A;
    do_op(4'h2, 4'hD, 3'b001, 1);

    // Randomized operations against the model
    for (int n = 0; n < 12; n++) begin
      mode = 1;
      salt = 8'($urandom);
      do_op(4'($urandom), 4'($urandom), 3'($urandom), $urandom_range(0, 3));
    end

`ifdef ALUSEQ_SWEEP_EN
    // Exhaustive sweep with out=A[0]; competing req_valid must lose to sweep_start
    mode = 2;
    exp_cnt = 0;
    for (int unsigned k = 0; k < 256; k++) begin
      v = 8'(k);
      exp_cnt += 32'(alu_model(v[3:0], v[7:4], 3'b000, mode, salt) >> 4);
    end
    bus.req_op = 3'b000; bus.req_a = 4'h9; bus.req_b = 4'h3;
    bus.req_valid = 1'b1; sweep_start = 1'b1;
    tick();
    bus.req_valid = 1'b0; sweep_start = 1'b0;
    check("sw_busy", bus.req_ready, 0);
    check("sw_alu_start", {alu_b, alu_a, alu_sel}, 0);
    done_at = 0; rv_seen = 0;
    for (int unsigned k = 1; k <= 1100; k++) begin
      tick();
      if (bus.rsp_valid) rv_seen++;
      if (sweep_done) begin
        done_at = k;
        break;
      end
    end
    check("sw_done_cycle", done_at, 256 * S);
    check("sw_count", sweep_count, exp_cnt);
    check("sw_no_rsp", rv_seen, 0);
    check("sw_idle_after", bus.req_ready, 1);
    tick();
    check("sw_done_pulse", sweep_done, 0);
    check("sw_count_hold", sweep_count, exp_cnt);
    mode = 1; salt = 8'h33;
    do_op(4'h4, 4'hB, 3'b100, 0);
    check("sw_count_hold2", sweep_count, exp_cnt);
`else
    // Without the sweep feature sweep_start is ignored
    sweep_start = 1'b1;
    done_at = 0; rv_seen = 0;
    for (int unsigned k = 0; k < 1100; k++) begin
      tick();
      if (sweep_done) done_at++;
      if (!bus.req_ready) rv_seen++;
    end
    sweep_start = 1'b0;
    check("nosw_done", done_at, 0);
    check("nosw_stays_idle", rv_seen, 0);
    check("nosw_count", sweep_count, 0);
    mode = 1; salt = 8'h33;
    do_op(4'h4, 4'hB, 3'b100, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
